// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the EX stage: owns HI/LO, sequences
// fixed-latency MULT/DIV operations and requests stalls for colliding MDU ops.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDU_op,
    input  logic [31:0] inputA,
    input  logic [31:0] inputB,
    input  logic        id_uses_mdu,
    output logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] mdu_rd,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e         r_state;
    state_e         w_stateNext;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cntNext;
    logic [CW-1:0]  w_loadCnt;
    logic [3:0]     r_op;
    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;
    logic [31:0]    w_hiNext;
    logic [31:0]    w_loNext;

    logic           w_isMulDiv;
    logic           w_finish;
    logic [63:0]    w_mulA;
    logic [63:0]    w_mulB;
    logic [63:0]    w_prod;
    logic [31:0]    w_divA;
    logic [31:0]    w_divB;
    logic [31:0]    w_quotMag;
    logic [31:0]    w_remMag;
    logic           w_negQuot;
    logic           w_negRem;
    logic [31:0]    w_resHi;
    logic [31:0]    w_resLo;
    logic           w_resWrite;

    assign w_isMulDiv = (MDU_op >= OP_MULT) && (MDU_op <= OP_DIVU);
    assign w_finish   = (r_state == S_RUN) && (r_cnt == CW'(1));
    assign w_loadCnt  = ((MDU_op == OP_MULT) || (MDU_op == OP_MULTU)) ? CW'(MULT_CYCLES)
                                                                     : CW'(DIV_CYCLES);

    // A new mult/div is also taken on the finishing edge so back-to-back issue has no gap.
    assign start     = w_isMulDiv && ((r_state == S_IDLE) || w_finish);
    assign busy      = (r_state == S_RUN);
    assign stall_req = id_uses_mdu && ((busy && !w_finish) || start);
    assign hi_out    = r_hi;
    assign lo_out    = r_lo;

    // One 64-bit multiplier serves both: sign-extension makes the low 64 bits the signed product.
    assign w_mulA = (r_op == OP_MULT) ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_mulB = (r_op == OP_MULT) ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod = w_mulA * w_mulB;

    // Signed division runs on magnitudes, then restores signs (quotient toward zero).
    assign w_divA    = ((r_op == OP_DIV) && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_divB    = ((r_op == OP_DIV) && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_quotMag = w_divA / w_divB;
    assign w_remMag  = w_divA % w_divB;
    assign w_negQuot = (r_op == OP_DIV) && (r_a[31] ^ r_b[31]);
    assign w_negRem  = (r_op == OP_DIV) && r_a[31];

    always_comb begin
        w_resHi    = r_hi;
        w_resLo    = r_lo;
        w_resWrite = 1'b0;
        case (r_op)
            OP_MULT, OP_MULTU: begin
                w_resHi    = w_prod[63:32];
                w_resLo    = w_prod[31:0];
                w_resWrite = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                if (r_b != 32'd0) begin
                    w_resLo    = w_negQuot ? (32'd0 - w_quotMag) : w_quotMag;
                    w_resHi    = w_negRem  ? (32'd0 - w_remMag)  : w_remMag;
                    w_resWrite = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_hiNext    = r_hi;
        w_loNext    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext = S_RUN;
                    w_cntNext   = w_loadCnt;
                end else if (MDU_op == OP_MTHI) begin
                    w_hiNext = inputA;
                end else if (MDU_op == OP_MTLO) begin
                    w_loNext = inputA;
                end
            end
            S_RUN: begin
                if (w_finish) begin
                    if (w_resWrite) begin
                        w_hiNext = w_resHi;
                        w_loNext = w_resLo;
                    end
                    if (start) begin
                        w_cntNext = w_loadCnt;
                    end else begin
                        w_stateNext = S_IDLE;
                        w_cntNext   = '0;
                    end
                end else begin
                    w_cntNext = r_cnt - CW'(1);
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_hi    <= w_hiNext;
            r_lo    <= w_loNext;
            if (start) begin
                r_op <= MDU_op;
                r_a  <= inputA;
                r_b  <= inputB;
            end
        end
    end

    always_comb begin
        mdu_rd = 32'd0;
        if (MDU_op == OP_MFHI) begin
            mdu_rd = r_hi;
        end else if (MDU_op == OP_MFLO) begin
            mdu_rd = r_lo;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a cycle-timestamp model of HI/LO and busy windows
// is compared every cycle, alongside hand-computed expectations for directed vectors.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDU_op;
    logic [31:0] inputA;
    logic [31:0] inputB;
    logic        id_uses_mdu;
    logic        start;
    logic        busy;
    logic        stall_req;
    logic [31:0] mdu_rd;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;

    int          cyc    = 0;
    int          mDone  = 0;
    logic [31:0] mHi    = 32'd0;
    logic [31:0] mLo    = 32'd0;
    logic [31:0] pHi    = 32'd0;
    logic [31:0] pLo    = 32'd0;
    bit          pWr    = 1'b0;
    bit          mValid = 1'b0;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MDU_op     (MDU_op),
        .inputA     (inputA),
        .inputB     (inputB),
        .id_uses_mdu(id_uses_mdu),
        .start      (start),
        .busy       (busy),
        .stall_req  (stall_req),
        .mdu_rd     (mdu_rd),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    function automatic bit isMulDiv(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic computeResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output bit wr);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = 32'd0;
        lo = 32'd0;
        wr = 1'b0;
        case (op)
            OP_MULT: begin
                q  = sa * sb;
                hi = q[63:32];
                lo = q[31:0];
                wr = 1'b1;
            end
            OP_MULTU: begin
                uq = ua * ub;
                hi = uq[63:32];
                lo = uq[31:0];
                wr = 1'b1;
            end
            OP_DIV: if (b != 32'd0) begin
                q  = sa / sb;
                r  = sa % sb;
                lo = q[31:0];
                hi = r[31:0];
                wr = 1'b1;
            end
            OP_DIVU: if (b != 32'd0) begin
                uq = ua / ub;
                ur = ua % ub;
                lo = uq[31:0];
                hi = ur[31:0];
                wr = 1'b1;
            end
            default: ;
        endcase
    endtask

    // Model: each accepted op owns a busy window ending at cycle mDone, when its result lands.
    initial begin
        bit wasBusy;
        bit acc;
        forever begin
            @(posedge clk);
            wasBusy = (cyc < mDone);
            acc     = isMulDiv(MDU_op) && (cyc + 1 >= mDone);
            cyc++;
            if (reset) begin
                mHi    = 32'd0;
                mLo    = 32'd0;
                mDone  = 0;
                mValid = 1'b1;
            end else begin
                if (wasBusy && (cyc == mDone) && pWr) begin
                    mHi = pHi;
                    mLo = pLo;
                end
                if (acc) begin
                    computeResult(MDU_op, inputA, inputB, pHi, pLo, pWr);
                    mDone = cyc + (((MDU_op == OP_MULT) || (MDU_op == OP_MULTU)) ? MULT_N : DIV_N);
                end else if (!wasBusy) begin
                    if (MDU_op == OP_MTHI) mHi = inputA;
                    else if (MDU_op == OP_MTLO) mLo = inputA;
                end
            end
        end
    end

    initial begin
        bit          eBusy, eFin, eStart, eStall;
        logic [31:0] eRd;
        forever begin
            @(negedge clk);
            if (mValid) begin
                eBusy  = (cyc < mDone);
                eFin   = eBusy && (cyc + 1 == mDone);
                eStart = isMulDiv(MDU_op) && (!eBusy || eFin);
                eStall = id_uses_mdu && ((eBusy && !eFin) || eStart);
                eRd    = (MDU_op == OP_MFHI) ? mHi : ((MDU_op == OP_MFLO) ? mLo : 32'd0);
                checkOutput($sformatf("busy@%0d", cyc),  32'(busy),      32'(eBusy));
                checkOutput($sformatf("start@%0d", cyc), 32'(start),     32'(eStart));
                checkOutput($sformatf("stall@%0d", cyc), 32'(stall_req), 32'(eStall));
                checkOutput($sformatf("hi@%0d", cyc),    hi_out,         mHi);
                checkOutput($sformatf("lo@%0d", cyc),    lo_out,         mLo);
                checkOutput($sformatf("rd@%0d", cyc),    mdu_rd,         eRd);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic idUse);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        MDU_op      = op;
        inputA      = a;
        inputB      = b;
        id_uses_mdu = idUse;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        reset       = 1'b1;
        MDU_op      = OP_NONE;
        id_uses_mdu = 1'b0;
    endtask

    task automatic doOp(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] expHi, input logic [31:0] expLo);
        int busyCnt;
        busyCnt = 0;
        applyStimulus(op, a, b, 1'b0);
        @(negedge clk);
        checkOutput({name, "_start"}, 32'(start), 32'd1);
        for (int i = 0; i < n; i++) begin
            applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
            @(negedge clk);
            if (busy) busyCnt++;
        end
        checkOutput({name, "_busyCycles"}, 32'(busyCnt), 32'(n));
        applyStimulus(OP_MFHI, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput({name, "_busyDone"}, 32'(busy), 32'd0);
        checkOutput({name, "_hi"}, hi_out, expHi);
        checkOutput({name, "_lo"}, lo_out, expLo);
        checkOutput({name, "_mfhi"}, mdu_rd, expHi);
        applyStimulus(OP_MFLO, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput({name, "_mflo"}, mdu_rd, expLo);
    endtask

    initial begin
        int stallCnt;
        reset       = 1'b1;
        MDU_op      = OP_NONE;
        inputA      = 32'd0;
        inputB      = 32'd0;
        id_uses_mdu = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_hi", hi_out, 32'd0);
        checkOutput("reset_lo", lo_out, 32'd0);
        checkOutput("reset_rd", mdu_rd, 32'd0);

        doOp("mult_neg",  OP_MULT,  32'hFFFF_FFFE, 32'd3,        MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        doOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 32'hFFFF_FFFE, 32'h0000_0001);
        doOp("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
        doOp("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0000_0000, 32'h8000_0000);
        doOp("divu",      OP_DIVU,  32'd100,       32'd7,        DIV_N,  32'd2,         32'd14);

        applyStimulus(OP_MTHI, 32'h11, 32'd0, 1'b0);
        applyStimulus(OP_MTLO, 32'h22, 32'd0, 1'b0);
        doOp("divu_zero", OP_DIVU,  32'd7,         32'd0,        DIV_N,  32'h11,        32'h22);

        // MFLO sits in ID for the whole operation.
        stallCnt = 0;
        applyStimulus(OP_MULT, 32'd5, 32'd7, 1'b1);
        @(negedge clk);
        if (stall_req) stallCnt++;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b1);
            @(negedge clk);
            if (stall_req) stallCnt++;
        end
        checkOutput("stall_cycles", 32'(stallCnt), 32'd5);
        checkOutput("stall_lo", lo_out, 32'd35);

        // Ops presented mid-run must be ignored.
        applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b0);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        applyStimulus(OP_MTLO, 32'h55, 32'd0, 1'b0);
        applyStimulus(OP_DIV,  32'd9, 32'd3, 1'b0);
        applyStimulus(OP_MTHI, 32'h66, 32'd0, 1'b0);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("ignore_busy", 32'(busy), 32'd0);
        checkOutput("ignore_lo", lo_out, 32'd12);
        checkOutput("ignore_hi", hi_out, 32'd0);

        // Reset in the third busy cycle of DIV 100/7.
        applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b0);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        pulseReset();
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_hi", hi_out, 32'd0);
        checkOutput("abort_lo", lo_out, 32'd0);
        for (int i = 0; i < 12; i++) applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("abort_late_hi", hi_out, 32'd0);
        checkOutput("abort_late_lo", lo_out, 32'd0);

        // Back-to-back MULTs: second issued in the first one's last busy cycle.
        applyStimulus(OP_MULT, 32'd2, 32'd3, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        applyStimulus(OP_MULT, 32'd4, 32'd5, 1'b0);
        @(negedge clk);
        checkOutput("b2b_start", 32'(start), 32'd1);
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("b2b_lo1", lo_out, 32'd6);
        checkOutput("b2b_busy2", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("b2b_lo1_hold", lo_out, 32'd6);
        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("b2b_lo2", lo_out, 32'd20);
        checkOutput("b2b_idle", 32'(busy), 32'd0);

        applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
